cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
- Consumes the free-running 32-bit clkdiv bus from the clock divider.
- Produces a single-cycle clock-enable pulse, cpu_en, that advances the pipelined MIPS CPU.
- Two modes: free-run, where the rate is set by the clkdiv bit chosen by rate_sel, and single-step, where each debounced press of the board step button gives one pulse.
- Keeps a 32-bit count of issued pulses for the display logic.

Parameters:
- DEB_BIT, 17: clkdiv bit whose rising edge is the debounce sample tick (~763 Hz at 200 MHz).
- DEB_DEPTH, 8: consecutive equal samples required to declare the button stable (range 2..16).

Ports:
- clk  input  1  system clock, same clock that drives the clock divider.
- rst  input  1  asynchronous, active-high reset.
- clkdiv  input  32  divider count, registered in the clk domain.
- rate_sel  input  5  index of the clkdiv bit used as the free-run rate; synchronous to clk.
- run_mode  input  1  board switch (asynchronous); 1 = free-run, 0 = single-step.
- step_btn  input  1  board push-button (asynchronous, bouncy), active-high.
- cpu_en  output  1  one-clk-wide CPU advance pulse.
- btn_stable  output  1  debounced button level.
- step_state  output  2  FSM state: 0 IDLE, 1 HELD, 2 RELEASE_WAIT.
- en_count  output  32  number of cpu_en pulses since reset; wraps at 2^32.

Behaviour:
- Reset: asynchronous, active-high. All registers clear immediately:
  - cpu_en = 0, btn_stable = 0, step_state = IDLE, en_count = 0.
  - Synchronizers, debounce shift register and edge-detect history = 0.
  - The armed flag clears.
- Armed flag: set on the first clk edge after rst deasserts. No edge detector reports an edge while armed = 0, so no spurious tick is generated from an arbitrary clkdiv value.
- Synchronization: run_mode and step_btn each pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Sample tick: asserted for one cycle when clkdiv[DEB_BIT] = 1 and the previous cycle's value = 0 (requires armed).
- Debounce:
  - On each sample tick, shift the synchronized button into a DEB_DEPTH-bit register.
  - btn_stable goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
  - btn_stable is registered and updates the cycle after the deciding tick.
- Step FSM:
  - IDLE -> HELD when btn_stable = 1.
  - HELD -> RELEASE_WAIT when btn_stable = 0.
  - RELEASE_WAIT -> IDLE on the next sample tick.
  - A step pulse is generated only on the IDLE->HELD transition and only if synced run_mode = 0. cpu_en is high for exactly one cycle, the cycle after the transition is registered.
  - The FSM tracks the button in both modes, so a press held while switching from run to step does not fire.
- Run tick:
  - Asserted when clkdiv[rate_sel] rises, i.e. the current value = 1 and the history register = 0.
  - The history register holds the previous cycle's value of clkdiv[rate_sel] with the previous rate_sel.
  - If rate_sel differs from its registered copy, the run tick is suppressed that cycle and history reloads from the new bit.
  - When synced run_mode = 1, cpu_en = registered run tick: one cycle after the edge appears on the clkdiv input.
- rate_sel = 0 with clkdiv incrementing every clk: a rising edge every 2 clks, so cpu_en pulses every other cycle.
- Mode switch:
  - A run_mode change takes effect 2 cycles after its input edge.
  - A run tick and a step transition in the same cycle: only the one matching the current mode fires. Never more than one pulse per cycle.
- en_count increments by 1 in every cycle that cpu_en = 1. 0xFFFFFFFF wraps to 0.
- Reset mid-press: the FSM returns to IDLE. Because btn_stable restarts at 0, the first stable-high after reset generates a pulse if run_mode = 0.

Test Plan (DEB_BIT=2, DEB_DEPTH=4, bench drives clkdiv from a counter incrementing each clk):
- Reset with run_mode=0, step_btn=0 -> all outputs 0. No cpu_en pulse for 100 cycles, including the first cycle after rst falls with clkdiv[2]=1.
- step_btn held high 60 cycles then low 60 -> btn_stable rises after 4 sample ticks (~32 cycles). Exactly one cpu_en pulse. en_count=1. FSM goes IDLE->HELD->RELEASE_WAIT->IDLE.
- step_btn toggling every 3 cycles for 40 cycles, then steady high -> no pulse during bounce, then exactly one pulse. en_count=1.
- run_mode=1, rate_sel=3 for 160 cycles -> cpu_en every 16 cycles, one cycle wide. en_count=10±1. step_btn presses produce no extra pulses.
- rate_sel changed 3->5 in the cycle clkdiv[5] is 1 and clkdiv[3] is 0 -> no pulse that cycle. Pulses then every 64 cycles.
- en_count preloaded via force to 0xFFFFFFFF, then one step press -> en_count=0. rst asserted mid-HELD -> step_state=0 immediately.

Source files
------------

// File: rtl/cpu_clk_ctrl_if.sv
// Signal bundle between the CPU clock-enable controller and the board/CPU side.
// The master drives the divider bus and board inputs; the slave (controller) returns enables and status.
interface cpu_clk_ctrl_if;
  logic [31:0] clkdiv;
  logic [4:0]  rate_sel;
  logic        run_mode;
  logic        step_btn;
  logic        cpu_en;
  logic        btn_stable;
  logic [1:0]  step_state;
  logic [31:0] en_count;

  modport master (
    output clkdiv, rate_sel, run_mode, step_btn,
    input  cpu_en, btn_stable, step_state, en_count
  );

  modport slave (
    input  clkdiv, rate_sel, run_mode, step_btn,
    output cpu_en, btn_stable, step_state, en_count
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: free-run pulses from a clkdiv bit, or one pulse per
// debounced step-button press, plus a running count of issued pulses.
module cpu_clk_ctrl #(
  parameter int unsigned DEB_BIT   = 17,
  parameter int unsigned DEB_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  cpu_clk_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HELD         = 2'd1,
    RELEASE_WAIT = 2'd2
  } step_t;

  step_t                state;
  logic                 armed;
  logic [1:0]           run_sync;
  logic [1:0]           btn_sync;
  logic                 run_s;
  logic                 btn_s;
  logic                 deb_hist;
  logic                 rate_hist;
  logic [4:0]           rate_q;
  logic [DEB_DEPTH-1:0] deb_sr;
  logic                 btn_stable_q;
  logic                 cpu_en_q;
  logic [31:0]          en_count_q;
  logic                 sample_tick;
  logic                 rate_bit;
  logic                 run_tick;
  logic                 step_fire;

  assign run_s = run_sync[1];
  assign btn_s = btn_sync[1];

  // Edge detectors stay silent until armed so a reset release onto a high clkdiv bit is not an edge.
  always_comb begin
    sample_tick = armed & bus.clkdiv[DEB_BIT] & ~deb_hist;
    rate_bit    = bus.clkdiv[bus.rate_sel];
    run_tick    = armed & (bus.rate_sel == rate_q) & rate_bit & ~rate_hist;
    step_fire   = (state == IDLE) & btn_stable_q & ~run_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      run_sync  <= '0;
      btn_sync  <= '0;
      deb_hist  <= 1'b0;
      rate_hist <= 1'b0;
      rate_q    <= '0;
    end else begin
      armed     <= 1'b1;
      run_sync  <= {run_sync[0], bus.run_mode};
      btn_sync  <= {btn_sync[0], bus.step_btn};
      deb_hist  <= bus.clkdiv[DEB_BIT];
      rate_hist <= rate_bit;
      rate_q    <= bus.rate_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_sr       <= '0;
      btn_stable_q <= 1'b0;
    end else begin
      if (sample_tick) begin
        deb_sr <= {deb_sr[DEB_DEPTH-2:0], btn_s};
      end
      if (&deb_sr) begin
        btn_stable_q <= 1'b1;
      end else if (~|deb_sr) begin
        btn_stable_q <= 1'b0;
      end
    end
  end

  // The FSM follows the button in both modes so a press carried across a mode switch never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cpu_en_q   <= 1'b0;
      en_count_q <= '0;
    end else begin
      cpu_en_q   <= run_s ? run_tick : step_fire;
      en_count_q <= en_count_q + {31'd0, cpu_en_q};
      case (state)
        IDLE:         if (btn_stable_q)  state <= HELD;
        HELD:         if (!btn_stable_q) state <= RELEASE_WAIT;
        RELEASE_WAIT: if (sample_tick)   state <= IDLE;
        default:                         state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.btn_stable = btn_stable_q;
  assign bus.step_state = state;
  assign bus.en_count   = en_count_q;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed scenarios plus random mode/rate/button
// activity, all checked cycle by cycle against a history-based reference model.
module tb_cpu_clk_ctrl;
  localparam int unsigned DB = 2;
  localparam int unsigned DD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cpu_clk_ctrl_if ifc ();

  cpu_clk_ctrl #(.DEB_BIT(DB), .DEB_DEPTH(DD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: synchronizers as 2-deep delay queues, debounce as a window of the
  // last DD samples, FSM as an integer phase.
  bit          preload_req = 1'b0;
  bit          m_armed     = 1'b0;
  bit          m_run_pipe[$];
  bit          m_btn_pipe[$];
  bit          m_samp[$];
  bit          m_stable    = 1'b0;
  int          m_phase     = 0;
  bit          m_en        = 1'b0;
  logic [31:0] m_cnt       = '0;
  bit          m_deb_prev  = 1'b0;
  bit          m_rate_prev = 1'b0;
  logic [4:0]  m_rs_prev   = '0;

  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run_pipe.delete(); m_run_pipe.push_back(1'b0); m_run_pipe.push_back(1'b0);
      m_btn_pipe.delete(); m_btn_pipe.push_back(1'b0); m_btn_pipe.push_back(1'b0);
      m_samp.delete();
      for (int unsigned i = 0; i < DD; i++) m_samp.push_back(1'b0);
      m_armed = 1'b0; m_stable = 1'b0; m_phase = 0; m_en = 1'b0; m_cnt = '0;
      m_deb_prev = 1'b0; m_rate_prev = 1'b0; m_rs_prev = '0;
    end else begin
      bit run_s, btn_s, tick, rbit, rtick, fire, nstable;
      int ones;
      run_s = m_run_pipe.pop_front(); m_run_pipe.push_back(ifc.run_mode);
      btn_s = m_btn_pipe.pop_front(); m_btn_pipe.push_back(ifc.step_btn);
      tick  = m_armed && ifc.clkdiv[DB] && !m_deb_prev;
      rbit  = ifc.clkdiv[ifc.rate_sel];
      rtick = m_armed && (ifc.rate_sel == m_rs_prev) && rbit && !m_rate_prev;
      ones  = 0;
      foreach (m_samp[i]) ones += int'(m_samp[i]);
      nstable = (ones == int'(DD)) ? 1'b1 : (ones == 0) ? 1'b0 : m_stable;
      fire  = (m_phase == 0) && m_stable && !run_s;
      m_cnt = (preload_req ? 32'hFFFF_FFFF : m_cnt) + 32'(m_en);
      m_en  = run_s ? rtick : fire;
      if (m_phase == 0 && m_stable) m_phase = 1;
      else if (m_phase == 1 && !m_stable) m_phase = 2;
      else if (m_phase == 2 && tick) m_phase = 0;
      if (tick) begin
        void'(m_samp.pop_front());
        m_samp.push_back(btn_s);
      end
      m_stable    = nstable;
      m_deb_prev  = ifc.clkdiv[DB];
      m_rate_prev = rbit;
      m_rs_prev   = ifc.rate_sel;
      m_armed     = 1'b1;
    end
  end

  int unsigned cyc_no = 0;
  int unsigned pulses = 0;
  bit          prev_en = 1'b0;
  bit          saw_rw  = 1'b0;
  int unsigned pulse_t[$];

  task automatic cyc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      preload_req = 1'b0;
      cyc_no++;
      check("cpu_en",     32'(ifc.cpu_en),     32'(m_en));
      check("btn_stable", 32'(ifc.btn_stable), 32'(m_stable));
      check("step_state", 32'(ifc.step_state), 32'(m_phase));
      check("en_count",   ifc.en_count,        m_cnt);
      if (ifc.cpu_en === 1'b1) begin
        check("en_width", 32'(prev_en), 32'd0);
        pulses++;
        pulse_t.push_back(cyc_no);
      end
      if (ifc.step_state === 2'd2) saw_rw = 1'b1;
      prev_en    = (ifc.cpu_en === 1'b1);
      ifc.clkdiv = ifc.clkdiv + 32'd1;
    end
  endtask

  int unsigned p0;
  int unsigned d;
  int unsigned guard;

  initial begin
    ifc.clkdiv   = '0;
    ifc.rate_sel = 5'd3;
    ifc.run_mode = 1'b0;
    ifc.step_btn = 1'b0;
    cyc(3);
    check("reset_cpu_en", 32'(ifc.cpu_en), 32'd0);
    check("reset_state",  32'(ifc.step_state), 32'd0);
    check("reset_count",  ifc.en_count, 32'd0);

    // Release reset onto a high debounce bit: no tick may be seen on that first edge.
    ifc.clkdiv = 32'd4;
    rst = 1'b0;
    p0 = pulses;
    cyc(100);
    check("idle_pulses", pulses - p0, 32'd0);

    // Clean press and release.
    p0 = pulses; saw_rw = 1'b0;
    ifc.step_btn = 1'b1;
    cyc(60);
    check("press_stable", 32'(ifc.btn_stable), 32'd1);
    check("press_held",   32'(ifc.step_state), 32'd1);
    ifc.step_btn = 1'b0;
    cyc(60);
    check("press_pulses", pulses - p0, 32'd1);
    check("press_count",  ifc.en_count, 32'd1);
    check("press_saw_rw", 32'(saw_rw), 32'd1);
    check("press_idle",   32'(ifc.step_state), 32'd0);

    // Bounce every 3 cycles, then a steady press.
    p0 = pulses;
    for (int unsigned i = 0; i < 13; i++) begin
      ifc.step_btn = ~ifc.step_btn;
      cyc(3);
    end
    check("bounce_pulses", pulses - p0, 32'd0);
    ifc.step_btn = 1'b1;
    cyc(60);
    ifc.step_btn = 1'b0;
    cyc(60);
    check("bounce_press_pulses", pulses - p0, 32'd1);
    check("bounce_press_count",  ifc.en_count, 32'd2);

    // Free-run at rate_sel=3 with a step press in the middle.
    ifc.run_mode = 1'b1;
    cyc(3);
    p0 = pulses;
    pulse_t.delete();
    for (int unsigned i = 0; i < 160; i++) begin
      if (i == 40) ifc.step_btn = 1'b1;
      if (i == 100) ifc.step_btn = 1'b0;
      cyc(1);
    end
    d = pulses - p0;
    check("run_pulse_count_in_range", 32'(d >= 9 && d <= 11), 32'd1);
    for (int i = 1; i < pulse_t.size(); i++)
      check("run_period16", pulse_t[i] - pulse_t[i-1], 32'd16);

    // Switch 3->5 on a value with clkdiv[5]=1 and previous clkdiv[3]=0.
    guard = 0;
    while ((ifc.clkdiv & 32'd63) != 32'd33 && guard < 100) begin
      cyc(1);
      guard++;
    end
    check("rsel_align", ifc.clkdiv & 32'd63, 32'd33);
    ifc.rate_sel = 5'd5;
    cyc(1);
    check("rsel_switch_no_pulse", 32'(ifc.cpu_en), 32'd0);
    pulse_t.delete();
    cyc(200);
    check("rate5_pulses", 32'(pulse_t.size() >= 3), 32'd1);
    for (int i = 1; i < pulse_t.size(); i++)
      check("run_period64", pulse_t[i] - pulse_t[i-1], 32'd64);

    // Counter wrap via preload, then a step press.
    ifc.run_mode = 1'b0;
    cyc(40);
    force dut.en_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.en_count_q;
    preload_req = 1'b1;
    ifc.step_btn = 1'b1;
    cyc(60);
    ifc.step_btn = 1'b0;
    cyc(60);
    check("wrap_count", ifc.en_count, 32'd0);

    // Reset while HELD, then the still-held button fires once after reset.
    ifc.step_btn = 1'b1;
    cyc(50);
    check("pre_rst_held", 32'(ifc.step_state), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_state",  32'(ifc.step_state), 32'd0);
    check("rst_async_stable", 32'(ifc.btn_stable), 32'd0);
    check("rst_async_count",  ifc.en_count, 32'd0);
    cyc(3);
    rst = 1'b0;
    cyc(60);
    check("post_rst_count", ifc.en_count, 32'd1);
    ifc.step_btn = 1'b0;
    cyc(60);

    // Random mode, rate and button activity.
    for (int unsigned seg = 0; seg < 40; seg++) begin
      int unsigned len;
      bit bouncy;
      ifc.run_mode = 1'($urandom_range(0, 1));
      ifc.rate_sel = 5'($urandom_range(0, 6));
      bouncy       = 1'($urandom_range(0, 1));
      ifc.step_btn = 1'($urandom_range(0, 1));
      len          = $urandom_range(20, 80);
      for (int unsigned i = 0; i < len; i++) begin
        if (bouncy && $urandom_range(0, 3) == 0) ifc.step_btn = ~ifc.step_btn;
        if ($urandom_range(0, 40) == 0) ifc.rate_sel = 5'($urandom_range(0, 6));
        cyc(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
